// File: rtl/scrambler.sv
// 64b/66b TX self-synchronous scrambler, G(x) = 1 + x^39 + x^58; optional bypass via SCRAMBLER_BYPASS_EN.
// Latency: one clock from an enabled edge to data_out; one block per clock at full rate.
// Backpressure: none; enable qualifies each block, and idle cycles hold both state and output.
module scrambler #(
    parameter logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] data_in,
    input  logic [1:0]  sync_info,
    input  logic        enable,
`ifdef SCRAMBLER_BYPASS_EN
    input  logic        bypass,
`endif
    output logic [65:0] data_out
);

    logic [57:0] r_state;
    logic [65:0] r_data_out;
    logic [63:0] w_scrambled;
    logic [57:0] w_state_next;

    // Bit-serial LFSR unrolled across the payload; bit 0 is the first bit on the wire.
    always_comb begin
        w_state_next = r_state;
        w_scrambled  = '0;
        for (int i = 0; i < 64; i++) begin
            w_scrambled[i] = data_in[i] ^ w_state_next[38] ^ w_state_next[57];
            w_state_next   = {w_state_next[56:0], w_scrambled[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SEED;
            r_data_out <= '0;
        end else if (enable) begin
`ifdef SCRAMBLER_BYPASS_EN
            if (bypass) begin
                r_data_out <= {sync_info, data_in};
            end else begin
                r_data_out <= {sync_info, w_scrambled};
                r_state    <= w_state_next;
            end
`else
            r_data_out <= {sync_info, w_scrambled};
            r_state    <= w_state_next;
`endif
        end
    end

    assign data_out = r_data_out;

endmodule

// File: tb/tb_scrambler.sv
// Randomized bench for scrambler: bit-serial queue reference model plus a reference descrambler.
module tb_scrambler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] data_in = '0;
    logic [1:0]  sync_info = 2'b10;
    logic        enable = 1'b0;
`ifdef SCRAMBLER_BYPASS_EN
    logic        bypass = 1'b0;
`endif
    logic [65:0] data_out;

    scrambler dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .sync_info (sync_info),
        .enable    (enable),
`ifdef SCRAMBLER_BYPASS_EN
        .bypass    (bypass),
`endif
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

    int n_chk  = 0;
    int n_pass = 0;

    // Transmitted-bit history: element 0 is o[n-58], element 57 is o[n-1].
    bit tx_hist[$];
    bit rx_hist[$];

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        tx_hist.delete();
        for (int j = 58; j >= 1; j--) tx_hist.push_back(SEED[j-1]);
    endtask

    function automatic logic [63:0] ref_scramble(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) begin
            o[i] = d[i] ^ tx_hist[19] ^ tx_hist[0];
            tx_hist.push_back(o[i]);
            void'(tx_hist.pop_front());
        end
        return o;
    endfunction

    function automatic logic [63:0] ref_descramble(input logic [63:0] o);
        logic [63:0] d;
        d = '0;
        for (int i = 0; i < 64; i++) begin
            d[i] = o[i] ^ rx_hist[19] ^ rx_hist[0];
            rx_hist.push_back(o[i]);
            void'(rx_hist.pop_front());
        end
        return d;
    endfunction

    // Present one block for a single clock and return the model's expected output.
    task automatic send(input logic [63:0] d, input logic [1:0] h, output logic [65:0] exp);
        data_in   = d;
        sync_info = h;
        enable    = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        exp    = {h, ref_scramble(d)};
    endtask

    logic [65:0] exp;
    logic [65:0] gold;
    logic [65:0] last;
    logic [63:0] d;
    logic [63:0] rd;
    logic [63:0] bb_d[10];
    logic [1:0]  bb_h[10];
    logic [1:0]  h;

    initial begin
        gold = {2'b10, 64'h03FF_FF80_0000_0000};
        model_reset();

        // Reset state and seed check
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out", data_out, 66'h0);
        send(64'h0, 2'b10, exp);
        check("seed_model", data_out, exp);
        check("seed_golden", data_out, gold);
        last = exp;

        // Hold on idle cycles with random data
        for (int c = 0; c < 65; c++) begin
            data_in   = {$urandom, $urandom};
            sync_info = 2'($urandom);
            @(posedge clk);
            #1;
            if (c % 16 == 0 || c == 64) check("hold", data_out, last);
        end
        send(64'h0, 2'b10, exp);
        check("after_hold", data_out, exp);

        // Random stream with sparse enables, plus descrambler round trip
        rx_hist.delete();
        for (int j = 0; j < 58; j++) rx_hist.push_back(1'($urandom));
        for (int b = 0; b < 200; b++) begin
            d = (b >= 100 && b < 110) ? 64'h1E00_0000_0000_0000 : {$urandom, $urandom};
            h = (b % 64 == 0) ? 2'b01 : 2'b10;
            send(d, h, exp);
            check("stream", data_out, exp);
            check("stream_hdr", {64'h0, data_out[65:64]}, {64'h0, h});
            rd = ref_descramble(data_out[63:0]);
            if (b > 0) check("roundtrip", {2'b00, rd}, {2'b00, d});
            repeat (65) begin
                data_in = {$urandom, $urandom};
                @(posedge clk);
            end
            #1;
        end

        // Reset mid-stream
        for (int b = 0; b < 50; b++) begin
            send({$urandom, $urandom}, 2'b10, exp);
            if (b % 10 == 0) check("pre_reset", data_out, exp);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_reset_out", data_out, 66'h0);
        model_reset();
        send(64'h0, 2'b10, exp);
        check("mid_reset_seed", data_out, gold);

        // Back-to-back blocks
        for (int k = 0; k < 10; k++) begin
            bb_d[k] = {$urandom, $urandom};
            bb_h[k] = 2'($urandom);
        end
        for (int k = 0; k < 10; k++) begin
            data_in   = bb_d[k];
            sync_info = bb_h[k];
            enable    = 1'b1;
            @(posedge clk);
            #1;
            exp = {bb_h[k], ref_scramble(bb_d[k])};
            check("back2back", data_out, exp);
        end
        enable = 1'b0;
        last   = exp;
        @(posedge clk);
        #1;
        check("b2b_hold", data_out, last);

`ifdef SCRAMBLER_BYPASS_EN
        bypass = 1'b1;
        d = {$urandom, $urandom};
        data_in   = d;
        sync_info = 2'b01;
        enable    = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        bypass = 1'b0;
        check("bypass", data_out, {2'b01, d});
        send(64'h0123_4567_89AB_CDEF, 2'b10, exp);
        check("after_bypass", data_out, exp);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
